// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/interrupt sequencer beside decode. Handles load-use stalls, taken-branch flushes and multi-cycle interrupt entry.
// Latency: hazard outputs are combinational from the inputs. Interrupt entry takes DRAIN_CYCLES+3 cycles after leaving IDLE.
// Backpressure: stalls with pc_write_o/ifid_write_o low and inserts bubbles with idex_flush_o. Interrupt entry is deferred while a hazard is present.
//
// Ports:
//   clk_i, rst_ni                         clock (rising edge) and asynchronous active-low reset
//   id_rsrc_i/id_rdst_i/id_use_*_i         decode-stage register reads
//   ex_mem_read_i/ex_rd_i/ex_branch_i      EX-stage load and taken-branch info
//   int_req_i                             level interrupt request, latched internally
//   pc_write_o ... int_ack_o              pipeline control outputs
//   stall_count_o                         saturating load-use stall counter
// Optional feature macro: STALL_CNT_EN. When it is undefined, stall_count_o is tied to 0.
module pipeline_hazard_ctrl #(
    parameter int REG_AW       = 3,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [REG_AW-1:0] id_rsrc_i,
    input  logic [REG_AW-1:0] id_rdst_i,
    input  logic              id_use_src_i,
    input  logic              id_use_dst_i,
    input  logic              ex_mem_read_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_branch_i,
    input  logic              int_req_i,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ifid_flush_o,
    output logic              idex_flush_o,
    output logic              int_push_pc_o,
    output logic              int_push_flags_o,
    output logic              int_vector_o,
    output logic              int_ack_o,
    output logic [CNT_W-1:0]  stall_count_o
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_PUSH_PC,
        ST_PUSH_FLAGS,
        ST_VECTOR
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            int_q, int_d;

    logic            lu;
    logic            pw_c, iw_c, iff_c, idf_c, ppc_c, pfl_c, vec_c, ack_c;

    // Load-use: R0 is not special-cased, a load to R0 still stalls a reader of R0.
    assign lu = ex_mem_read_i &
                ((id_use_src_i & (id_rsrc_i == ex_rd_i)) |
                 (id_use_dst_i & (id_rdst_i == ex_rd_i)));

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        pw_c    = 1'b1;
        iw_c    = 1'b1;
        iff_c   = 1'b0;
        idf_c   = 1'b0;
        ppc_c   = 1'b0;
        pfl_c   = 1'b0;
        vec_c   = 1'b0;
        ack_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ex_branch_i) begin
                    iff_c = 1'b1;
                    idf_c = 1'b1;
                end else if (lu) begin
                    pw_c  = 1'b0;
                    iw_c  = 1'b0;
                    idf_c = 1'b1;
                end
                // Interrupt waits until the hazard cycle has been serviced.
                if (int_q && !ex_branch_i && !lu) begin
                    state_d = ST_DRAIN;
                    drain_d = DW'(DRAIN_CYCLES - 1);
                end
            end
            ST_DRAIN: begin
                // A branch already in EX still redirects so the pushed PC is its target.
                pw_c  = ex_branch_i;
                iff_c = ex_branch_i;
                iw_c  = 1'b0;
                idf_c = 1'b1;
                if (drain_q == '0) begin
                    state_d = ST_PUSH_PC;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            ST_PUSH_PC: begin
                pw_c    = 1'b0;
                iw_c    = 1'b0;
                idf_c   = 1'b1;
                ppc_c   = 1'b1;
                state_d = ST_PUSH_FLAGS;
            end
            ST_PUSH_FLAGS: begin
                pw_c    = 1'b0;
                iw_c    = 1'b0;
                idf_c   = 1'b1;
                pfl_c   = 1'b1;
                state_d = ST_VECTOR;
            end
            ST_VECTOR: begin
                iff_c   = 1'b1;
                idf_c   = 1'b1;
                vec_c   = 1'b1;
                ack_c   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A request still high on the ack edge re-arms the latch.
    assign int_d = int_req_i | (int_q & ~ack_c);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            drain_q <= '0;
            int_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            int_q   <= int_d;
        end
    end

    // Outputs are forced to their idle values while reset is held, independent of inputs.
    assign pc_write_o       = ~rst_ni | pw_c;
    assign ifid_write_o     = ~rst_ni | iw_c;
    assign ifid_flush_o     = rst_ni & iff_c;
    assign idex_flush_o     = rst_ni & idf_c;
    assign int_push_pc_o    = rst_ni & ppc_c;
    assign int_push_flags_o = rst_ni & pfl_c;
    assign int_vector_o     = rst_ni & vec_c;
    assign int_ack_o        = rst_ni & ack_c;

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == ST_IDLE) && lu && !ex_branch_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_count_o = cnt_q;
`else
    assign stall_count_o = '0;
`endif

endmodule
